// File: rtl/cfg_bus_router_pkg.sv
// Shared configuration memory map: address type, region bases, default mask and error word,
// plus the router state encoding and region decode helper.
package cfg_bus_router_pkg;

    typedef logic [15:0] cfg_addr_t;

    localparam logic [3:0] REGION_PC         = 4'h0;
    localparam logic [3:0] REGION_HD_MEM     = 4'h1;
    localparam logic [3:0] REGION_SMI        = 4'h2;
    localparam logic [3:0] REGION_IMEM       = 4'h3;
    localparam logic [3:0] REGION_OFFSET_CNT = 4'h4;
    localparam logic [3:0] REGION_PREPROC    = 4'h5;
    localparam logic [3:0] REGION_IO_CFG     = 4'h6;
    localparam logic [3:0] REGION_DMA        = 4'h7;
    localparam logic [3:0] REGION_IRQ        = 4'h8;
    localparam logic [3:0] REGION_PERF       = 4'h9;
    localparam logic [3:0] REGION_DEBUG      = 4'hA;
    localparam logic [3:0] REGION_CTRL       = 4'hB;
    localparam logic [3:0] REGION_STATUS     = 4'hC;

    localparam logic [15:0] CFG_REGION_MASK = 16'h1FFF;
    localparam logic [31:0] CFG_ERR_RDATA   = 32'hBADC_AB1E;

    typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} router_state_e;

    function automatic logic [3:0] region_of(cfg_addr_t addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/cfg_bus_router_if.sv
// Config bus bundle: master-side request/response plus the 16-way slave fan-out.
// The router uses the slave modport; the environment (config master and slaves) uses master.
interface cfg_bus_router_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import cfg_bus_router_pkg::*;

    logic                       mst_req;
    logic                       mst_gnt;
    cfg_addr_t                  mst_addr;
    logic                       mst_we;
    logic [DATA_WIDTH-1:0]      mst_wdata;
    logic                       mst_rvalid;
    logic [DATA_WIDTH-1:0]      mst_rdata;
    logic                       mst_err;

    logic [15:0]                slv_req;
    logic [15:0]                slv_gnt;
    logic [11:0]                slv_addr;
    logic                       slv_we;
    logic [DATA_WIDTH-1:0]      slv_wdata;
    logic [15:0]                slv_rvalid;
    logic [16*DATA_WIDTH-1:0]   slv_rdata;

    modport slave (
        input  mst_req, mst_addr, mst_we, mst_wdata,
        output mst_gnt, mst_rvalid, mst_rdata, mst_err,
        output slv_req, slv_addr, slv_we, slv_wdata,
        input  slv_gnt, slv_rvalid, slv_rdata
    );

    modport master (
        output mst_req, mst_addr, mst_we, mst_wdata,
        input  mst_gnt, mst_rvalid, mst_rdata, mst_err,
        input  slv_req, slv_addr, slv_we, slv_wdata,
        output slv_gnt, slv_rvalid, slv_rdata
    );

endinterface

// File: rtl/cfg_bus_router.sv
// Single-master config bus router: decodes addr[15:12], forwards one transaction at a time
// to the selected slave and always returns a response (data, ack or error on unmapped/timeout).
module cfg_bus_router
    import cfg_bus_router_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [15:0]           REGION_MASK    = CFG_REGION_MASK,
    parameter int unsigned           TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(CFG_ERR_RDATA)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cfg_bus_router_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    router_state_e          state_reg,  state_next;
    logic [3:0]             region_reg, region_next;
    logic [11:0]            offset_reg, offset_next;
    logic                   we_reg,     we_next;
    logic [DATA_WIDTH-1:0]  wdata_reg,  wdata_next;
    logic [CNT_W-1:0]       cnt_reg,    cnt_next;
    logic [DATA_WIDTH-1:0]  rdata_reg,  rdata_next;
    logic                   err_reg,    err_next;

    logic                   grant;
    logic [3:0]             req_region;
    logic                   sel_gnt;
    logic                   sel_rvalid;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   timeout;

    assign grant      = (state_reg == IDLE) && bus.mst_req;
    assign req_region = region_of(bus.mst_addr);
    assign sel_gnt    = bus.slv_gnt[region_reg];
    assign sel_rvalid = bus.slv_rvalid[region_reg];
    assign sel_rdata  = bus.slv_rdata[region_reg*DATA_WIDTH +: DATA_WIDTH];
    assign timeout    = (cnt_reg == TO_LAST);

    always_comb begin
        state_next  = state_reg;
        region_next = region_reg;
        offset_next = offset_reg;
        we_next     = we_reg;
        wdata_next  = wdata_reg;
        cnt_next    = cnt_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (grant) begin
                    region_next = req_region;
                    offset_next = bus.mst_addr[11:0];
                    we_next     = bus.mst_we;
                    wdata_next  = bus.mst_wdata;
                    cnt_next    = '0;
                    if (REGION_MASK[req_region]) begin
                        state_next = FWD;
                    end else begin
                        state_next = RESP;
                        rdata_next = ERR_RDATA;
                        err_next   = 1'b1;
                    end
                end
            end
            FWD: begin
                cnt_next = cnt_reg + 1'b1;
                // A same-cycle completion beats the timeout; a bare grant does not.
                if (sel_gnt && sel_rvalid) begin
                    state_next = RESP;
                    rdata_next = we_reg ? '0 : sel_rdata;
                    err_next   = 1'b0;
                end else if (timeout) begin
                    state_next = RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end else if (sel_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (sel_rvalid) begin
                    state_next = RESP;
                    rdata_next = we_reg ? '0 : sel_rdata;
                    err_next   = 1'b0;
                end else if (timeout) begin
                    state_next = RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            region_reg <= '0;
            offset_reg <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            region_reg <= region_next;
            offset_reg <= offset_next;
            we_reg     <= we_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
        end
    end

    assign bus.mst_gnt    = grant;
    assign bus.mst_rvalid = (state_reg == RESP);
    assign bus.mst_rdata  = rdata_reg;
    assign bus.mst_err    = err_reg;

    assign bus.slv_req    = (state_reg == FWD) ? (16'd1 << region_reg) : 16'd0;
    assign bus.slv_addr   = offset_reg;
    assign bus.slv_we     = we_reg;
    assign bus.slv_wdata  = wdata_reg;

endmodule

// File: tb/tb_cfg_bus_router.sv
// Directed and randomized transactions against a cycle-count reference model of the router;
// each check is an immediate assertion, with one summary line at the end.
module tb_cfg_bus_router;
    import cfg_bus_router_pkg::*;

    localparam int          DW   = 32;
    localparam int          TO   = 16;
    localparam logic [15:0] MASK = 16'h1FFF;
    localparam logic [31:0] ERRW = 32'hBADC_AB1E;
    localparam int          NEVER = 1000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    cfg_bus_router_if #(.DATA_WIDTH(DW)) bus ();

    cfg_bus_router #(
        .DATA_WIDTH(DW),
        .REGION_MASK(MASK),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA(ERRW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Response timing from the rules alone: unmapped answers next cycle; otherwise the
    // response follows the rvalid cycle if both grant and rvalid land within TO cycles.
    task automatic model(input logic [15:0] addr, input logic we, input int g, input int v,
                         input logic [31:0] sdata, output int lat, output logic err,
                         output logic [31:0] rdata, output int req_last);
        int r;
        r = int'(addr[15:12]);
        if (!MASK[r]) begin
            lat = 1; err = 1'b1; rdata = ERRW; req_last = 0;
        end else begin
            req_last = (g < TO) ? g : TO;
            if (g <= TO && v <= TO) begin
                lat = v + 1; err = 1'b0; rdata = we ? 32'd0 : sdata;
            end else begin
                lat = TO + 1; err = 1'b1; rdata = ERRW;
            end
        end
    endtask

    task automatic quiet_inputs();
        bus.mst_req    = 1'b0;
        bus.mst_addr   = '0;
        bus.mst_we     = 1'b0;
        bus.mst_wdata  = '0;
        bus.slv_gnt    = '0;
        bus.slv_rvalid = '0;
        bus.slv_rdata  = '0;
    endtask

    // One transaction: cycle 0 is the grant cycle, g/v are the slave's grant/rvalid cycles.
    task automatic run_txn(input string tag, input logic [15:0] addr, input logic we,
                           input logic [31:0] wdata, input int g, input int v,
                           input logic [31:0] sdata, input int rst_at);
        int             lat, req_last, r;
        logic           e_err;
        logic [31:0]    e_rdata;
        logic [15:0]    oh, strobes;
        logic [511:0]   rd;
        logic           mapped;

        model(addr, we, g, v, sdata, lat, e_err, e_rdata, req_last);
        r      = int'(addr[15:12]);
        mapped = MASK[r];
        oh     = 16'd1 << r;

        bus.mst_req    = 1'b1;
        bus.mst_addr   = addr;
        bus.mst_we     = we;
        bus.mst_wdata  = wdata;
        bus.slv_gnt    = 16'($urandom);
        bus.slv_rvalid = 16'($urandom);
        for (int i = 0; i < 16; i++) rd[i*32 +: 32] = $urandom;
        bus.slv_rdata  = rd;
        #1;
        check({tag, " gnt c0"}, 64'(bus.mst_gnt), 64'd1);
        check({tag, " rvalid c0"}, 64'(bus.mst_rvalid), 64'd0);
        @(posedge clk);
        @(negedge clk);

        for (int k = 1; k <= lat + 1; k++) begin
            bus.mst_req   = (k == lat);
            bus.mst_addr  = 16'($urandom);
            bus.mst_we    = 1'($urandom);
            bus.mst_wdata = $urandom;
            strobes = 16'($urandom) & ~oh;
            if (mapped && k == g && g <= TO) strobes = strobes | oh;
            bus.slv_gnt = strobes;
            strobes = 16'($urandom) & ~oh;
            if (k == v) strobes = strobes | oh;
            bus.slv_rvalid = strobes;
            for (int i = 0; i < 16; i++) rd[i*32 +: 32] = $urandom;
            if (k == v) rd[r*32 +: 32] = sdata;
            bus.slv_rdata = rd;
            if (k == rst_at) rst_n = 1'b0;
            #1;
            check($sformatf("%s slv_req c%0d", tag, k), 64'(bus.slv_req),
                  64'((k <= req_last) ? oh : 16'd0));
            check($sformatf("%s rvalid c%0d", tag, k), 64'(bus.mst_rvalid), 64'(k == lat));
            check($sformatf("%s slv_addr c%0d", tag, k), 64'(bus.slv_addr), 64'(addr[11:0]));
            check($sformatf("%s slv_we c%0d", tag, k), 64'(bus.slv_we), 64'(we));
            check($sformatf("%s slv_wdata c%0d", tag, k), 64'(bus.slv_wdata), 64'(wdata));
            if (k == lat) begin
                check({tag, " rdata"}, 64'(bus.mst_rdata), 64'(e_rdata));
                check({tag, " err"}, 64'(bus.mst_err), 64'(e_err));
                check({tag, " gnt in resp"}, 64'(bus.mst_gnt), 64'd0);
            end
            @(posedge clk);
            @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b1;
                quiet_inputs();
                #1;
                check({tag, " post-rst state"}, 64'(dut.state_reg), 64'(IDLE));
                check({tag, " post-rst rvalid"}, 64'(bus.mst_rvalid), 64'd0);
                check({tag, " post-rst slv_req"}, 64'(bus.slv_req), 64'd0);
                check({tag, " post-rst slv_addr"}, 64'(bus.slv_addr), 64'd0);
                @(posedge clk);
                @(negedge clk);
                check({tag, " post-rst idle rvalid"}, 64'(bus.mst_rvalid), 64'd0);
                $display("txn %s addr=%h we=%0d reset at cycle %0d", tag, addr, we, k);
                return;
            end
        end
        $display("txn %s addr=%h we=%0d g=%0d v=%0d -> lat=%0d err=%0d rdata=%h",
                 tag, addr, we, g, v, lat, e_err, e_rdata);
    endtask

    initial begin
        logic [15:0] a;
        logic        w;
        int          g;
        int          v;

        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        quiet_inputs();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst gnt",       64'(bus.mst_gnt),    64'd0);
        check("rst rvalid",    64'(bus.mst_rvalid), 64'd0);
        check("rst err",       64'(bus.mst_err),    64'd0);
        check("rst rdata",     64'(bus.mst_rdata),  64'd0);
        check("rst slv_req",   64'(bus.slv_req),    64'd0);
        check("rst slv_addr",  64'(bus.slv_addr),   64'd0);
        check("rst slv_we",    64'(bus.slv_we),     64'd0);
        check("rst slv_wdata", 64'(bus.slv_wdata),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset: outputs checked");

        // Directed cases
        run_txn("read2004",   16'h2004, 1'b0, 32'h0,        1,     2,      32'h1234_5678, 0);
        run_txn("writeB300",  16'hB300, 1'b1, 32'h0000_0003, 1,    1,      32'hDEAD_BEEF, 0);
        run_txn("unmapF000",  16'hF000, 1'b0, 32'h0,        1,     1,      32'h5555_5555, 0);
        run_txn("unmapD123",  16'hD123, 1'b1, 32'hCAFE_0001, 1,    1,      32'h0,         0);
        run_txn("timeout4",   16'h4000, 1'b0, 32'h0,        NEVER, TO + 2, 32'h7777_7777, 0);
        run_txn("lastcycle",  16'h5010, 1'b0, 32'h0,        1,     TO,     32'hA5A5_0F0F, 0);
        run_txn("lastcombo",  16'h6020, 1'b0, 32'h0,        TO,    TO,     32'h0F0F_A5A5, 0);
        run_txn("gntlast",    16'h7030, 1'b0, 32'h0,        TO,    TO + 1, 32'h1111_2222, 0);
        run_txn("rstwait",    16'h3010, 1'b0, 32'h0,        1,     NEVER,  32'h0,         3);
        run_txn("read0000",   16'h0000, 1'b0, 32'h0,        1,     2,      32'h0BAD_F00D, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            a = 16'($urandom);
            w = 1'($urandom);
            g = 1 + int'($urandom_range(0, TO + 1));
            v = g + int'($urandom_range(0, 3));
            run_txn($sformatf("rand%0d", t), a, w, $urandom, g, v, $urandom, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
